// File: rtl/sv_remapper_12k_pkg.sv
// rtl/sv_remapper_12k_pkg.sv - shared types and sizing helpers for the frame checker
package sv_remapper_12k_pkg;

    typedef enum logic [0:0] {
        S_WAIT_SOF,
        S_FRAME
    } frame_state_t;

    // Sideband stored alongside each pixel; a FIFO word is {tag, tdata}.
    typedef struct packed {
        logic tuser;
        logic tlast;
    } frame_tag_t;

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int entry_width(input int data_width);
        return data_width + $bits(frame_tag_t);
    endfunction

endpackage

// File: rtl/sv_sync_fifo.sv
// rtl/sv_sync_fifo.sv - first-word-fall-through synchronous FIFO with level output
module sv_sync_fifo
    import sv_remapper_12k_pkg::*;
#(
    parameter int ENTRY_WIDTH = 10,
    parameter int DEPTH       = 512
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [ENTRY_WIDTH-1:0]        s_tdata,
    input  logic                          s_tvalid,
    output logic [ENTRY_WIDTH-1:0]        m_tdata,
    input  logic                          m_tready,
    output logic                          full,
    output logic                          empty,
    output logic [level_width(DEPTH)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [ENTRY_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [LW-1:0]          count;
    logic                   wr_en;
    logic                   rd_en;

    // Full comes from the registered count, so a write at full is refused even with a same-cycle read.
    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    assign level = count;
    assign wr_en = s_tvalid && !full;
    assign rd_en = m_tready && !empty;

    assign m_tdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sv_axis_frame_checker.sv
// rtl/sv_axis_frame_checker.sv - frame geometry checker with tuser/tlast regeneration and output buffer
module sv_axis_frame_checker
    import sv_remapper_12k_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 512,
    parameter int DIM_WIDTH  = 16
) (
    input  logic                               i_clk,
    input  logic                               i_aresetn,
    input  logic [DIM_WIDTH-1:0]               WIDTH,
    input  logic [DIM_WIDTH-1:0]               HEIGHT,
    input  logic [DATA_WIDTH-1:0]              s_axis_tdata,
    input  logic                               s_axis_tvalid,
    input  logic                               s_axis_tuser,
    input  logic                               s_axis_tlast,
    output logic                               s_axis_tready,
    output logic [DATA_WIDTH-1:0]              m_axis_tdata,
    output logic                               m_axis_tvalid,
    output logic                               m_axis_tuser,
    output logic                               m_axis_tlast,
    input  logic                               m_axis_tready,
    input  logic                               i_err_clr,
    output logic                               o_err_line,
    output logic                               o_err_sof,
    output logic                               o_overflow,
    output logic [15:0]                        o_frame_cnt,
    output logic [level_width(FIFO_DEPTH)-1:0] o_fifo_level
);

    localparam int EW = entry_width(DATA_WIDTH);

    frame_state_t         state_q, state_d;
    logic [DIM_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [DIM_WIDTH-1:0] cur_x, cur_y;
    logic [DIM_WIDTH-1:0] width_m1, height_m1;
    logic [15:0]          frame_cnt_q;
    logic                 err_line_q, err_sof_q, overflow_q;

    logic       fsm_accept;
    logic       sof_beat;
    logic       line_end;
    logic       frame_end;
    logic       set_line, set_sof, set_ovf;
    logic       cnt_inc;
    frame_tag_t wr_tag, rd_tag;

    logic          fifo_wr;
    logic          fifo_full;
    logic          fifo_empty;
    logic [EW-1:0] fifo_rd_data;

    assign width_m1  = WIDTH - 1'b1;
    assign height_m1 = HEIGHT - 1'b1;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        fsm_accept = 1'b0;
        sof_beat   = 1'b0;
        set_sof    = 1'b0;
        set_line   = 1'b0;
        cnt_inc    = 1'b0;

        if (s_axis_tvalid) begin
            if (state_q == S_WAIT_SOF) begin
                fsm_accept = s_axis_tuser;
                sof_beat   = s_axis_tuser;
            end else begin
                fsm_accept = 1'b1;
                sof_beat   = s_axis_tuser;
                set_sof    = s_axis_tuser && ((x_q != '0) || (y_q != '0));
            end
        end

        // A start-of-frame beat (first or resync) is always pixel (0,0) of a fresh frame.
        cur_x     = sof_beat ? '0 : x_q;
        cur_y     = sof_beat ? '0 : y_q;
        line_end  = (cur_x == width_m1);
        frame_end = line_end && (cur_y == height_m1);

        if (fsm_accept) begin
            set_line = (s_axis_tlast != line_end);
            state_d  = S_FRAME;
            if (line_end) begin
                x_d = '0;
                y_d = cur_y + 1'b1;
            end else begin
                x_d = cur_x + 1'b1;
                y_d = cur_y;
            end
            if (frame_end) begin
                state_d = S_WAIT_SOF;
                cnt_inc = 1'b1;
            end
        end

        wr_tag.tuser = sof_beat;
        wr_tag.tlast = line_end;
    end

    // Counters advance even when the FIFO drops the beat, keeping geometry aligned.
    assign fifo_wr = fsm_accept && !fifo_full;
    assign set_ovf = fsm_accept && fifo_full;

    always_ff @(posedge i_clk) begin
        if (!i_aresetn) begin
            state_q     <= S_WAIT_SOF;
            x_q         <= '0;
            y_q         <= '0;
            frame_cnt_q <= '0;
            err_line_q  <= 1'b0;
            err_sof_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            if (cnt_inc) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            err_line_q  <= set_line | (err_line_q & ~i_err_clr);
            err_sof_q   <= set_sof  | (err_sof_q  & ~i_err_clr);
            overflow_q  <= set_ovf  | (overflow_q & ~i_err_clr);
        end
    end

    sv_sync_fifo #(
        .ENTRY_WIDTH (EW),
        .DEPTH       (FIFO_DEPTH)
    ) u_fifo (
        .clk      (i_clk),
        .resetn   (i_aresetn),
        .s_tdata  ({wr_tag, s_axis_tdata}),
        .s_tvalid (fifo_wr),
        .m_tdata  (fifo_rd_data),
        .m_tready (m_axis_tready),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (o_fifo_level)
    );

    assign {rd_tag, m_axis_tdata} = fifo_rd_data;
    assign m_axis_tuser  = rd_tag.tuser;
    assign m_axis_tlast  = rd_tag.tlast;
    assign m_axis_tvalid = !fifo_empty;
    assign s_axis_tready = !fifo_full;

    assign o_err_line  = err_line_q;
    assign o_err_sof   = err_sof_q;
    assign o_overflow  = overflow_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sv_axis_frame_checker.sv
// tb/tb_sv_axis_frame_checker.sv - randomized self-checking bench for sv_axis_frame_checker
module tb_sv_axis_frame_checker;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int DIMW  = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [DIMW-1:0] width_r = 16'd8;
    logic [DIMW-1:0] height_r = 16'd4;
    logic [DW-1:0]   s_d = '0;
    logic            s_v = 1'b0, s_u = 1'b0, s_l = 1'b0;
    logic            s_rdy;
    logic [DW-1:0]   m_d;
    logic            m_v, m_u, m_l;
    logic            m_rdy = 1'b1;
    logic            clr = 1'b0;
    logic            err_line, err_sof, ovf;
    logic [15:0]     frame_cnt;
    logic [LW-1:0]   level;

    int errors = 0;
    int checks = 0;

    logic [DW+1:0] q[$];
    bit            m_in_frame;
    int            m_p;
    logic [15:0]   m_cnt;
    bit            m_el, m_es, m_ov;
    logic [1:0]    obs[$];

    always #5 clk = ~clk;

    sv_axis_frame_checker #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .DIM_WIDTH  (DIMW)
    ) dut (
        .i_clk         (clk),
        .i_aresetn     (rst_n),
        .WIDTH         (width_r),
        .HEIGHT        (height_r),
        .s_axis_tdata  (s_d),
        .s_axis_tvalid (s_v),
        .s_axis_tuser  (s_u),
        .s_axis_tlast  (s_l),
        .s_axis_tready (s_rdy),
        .m_axis_tdata  (m_d),
        .m_axis_tvalid (m_v),
        .m_axis_tuser  (m_u),
        .m_axis_tlast  (m_l),
        .m_axis_tready (m_rdy),
        .i_err_clr     (clr),
        .o_err_line    (err_line),
        .o_err_sof     (err_sof),
        .o_overflow    (ovf),
        .o_frame_cnt   (frame_cnt),
        .o_fifo_level  (level)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: pixel index p within the frame, line end where (p mod W) == W-1.
    task automatic model_step();
        bit            pop, full, acc, sof, exp_last;
        bit            set_l, set_s, set_o;
        logic [DW+1:0] e;
        int            w, h;
        w = int'(width_r);
        h = int'(height_r);
        if (!rst_n) begin
            q.delete();
            m_in_frame = 0; m_p = 0; m_cnt = '0;
            m_el = 0; m_es = 0; m_ov = 0;
            return;
        end
        pop = (q.size() != 0) && m_rdy;
        full = (q.size() == DEPTH);
        acc = 0; sof = 0; set_l = 0; set_s = 0; set_o = 0; e = '0;
        if (s_v) begin
            if (!m_in_frame) begin
                acc = s_u; sof = s_u;
            end else begin
                acc = 1; sof = s_u; set_s = s_u;
            end
        end
        if (acc) begin
            if (sof) m_p = 0;
            exp_last = ((m_p % w) == w - 1);
            e = {(m_p == 0), exp_last, s_d};
            set_l = (s_l != exp_last);
            set_o = full;
            if (m_p == w * h - 1) begin
                m_cnt = m_cnt + 16'd1;
                m_in_frame = 0;
            end else begin
                m_p++;
                m_in_frame = 1;
            end
        end
        m_el = set_l || (m_el && !clr);
        m_es = set_s || (m_es && !clr);
        m_ov = set_o || (m_ov && !clr);
        if (pop) void'(q.pop_front());
        if (acc && !full) q.push_back(e);
    endtask

    task automatic check_outputs();
        chk("m_tvalid", m_v, q.size() != 0);
        if (q.size() != 0) chk("m_beat", {m_u, m_l, m_d}, q[0]);
        chk("level", level, q.size());
        chk("s_tready", s_rdy, q.size() != DEPTH);
        chk("err_line", err_line, m_el);
        chk("err_sof", err_sof, m_es);
        chk("overflow", ovf, m_ov);
        chk("frame_cnt", frame_cnt, m_cnt);
    endtask

    task automatic tick();
        if (m_v && m_rdy) obs.push_back({m_u, m_l});
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit v, input bit u, input bit l, input bit rdy);
        s_v = v; s_u = u; s_l = l; s_d = DW'($urandom); m_rdy = rdy;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 1);
    endtask

    task automatic send_frame(input int w, input int h, input bit rdy);
        for (int i = 0; i < w * h; i++) drive(1, i == 0, (i % w) == w - 1, rdy);
    endtask

    task automatic check_pattern(input string tag, input int n, input int w);
        chk({tag, "_beats"}, obs.size(), n);
        for (int i = 0; i < obs.size() && i < n; i++) begin
            chk({tag, "_tuser"}, obs[i][1], i == 0);
            chk({tag, "_tlast"}, obs[i][0], (i % w) == w - 1);
        end
    endtask

    initial begin
        int w, h;
        // Reset state
        rst_n = 0;
        tick();
        tick();
        chk("rst_tvalid", m_v, 0);
        chk("rst_tready", s_rdy, 1);
        chk("rst_level", level, 0);
        chk("rst_flags", {err_line, err_sof, ovf}, 0);
        chk("rst_cnt", frame_cnt, 0);
        rst_n = 1;

        // Clean 8x4 frame
        obs.delete();
        send_frame(8, 4, 1);
        idle(4);
        check_pattern("clean", 32, 8);
        chk("clean_cnt", frame_cnt, 1);
        chk("clean_flags", {err_line, err_sof, ovf}, 0);

        // Leading beats without tuser are discarded
        obs.delete();
        for (int i = 0; i < 5; i++) drive(1, 0, 0, 1);
        send_frame(8, 4, 1);
        idle(4);
        check_pattern("junk", 32, 8);
        chk("junk_cnt", frame_cnt, 2);

        // Early tlast at x=5 on line 1
        obs.delete();
        for (int i = 0; i < 32; i++) drive(1, i == 0, ((i % 8) == 7) || (i == 13), 1);
        idle(4);
        check_pattern("line", 32, 8);
        chk("line_err", err_line, 1);
        chk("line_cnt", frame_cnt, 3);
        clr = 1; idle(1); clr = 0;
        chk("line_clr", err_line, 0);

        // tuser injected at x=3,y=2 starts a new frame
        obs.delete();
        for (int i = 0; i < 19; i++) drive(1, i == 0, (i % 8) == 7, 1);
        send_frame(8, 4, 1);
        idle(4);
        chk("sof_err", err_sof, 1);
        chk("sof_cnt", frame_cnt, 4);
        chk("sof_beats", obs.size(), 51);
        if (obs.size() == 51) chk("sof_new_tuser", obs[19][1], 1);
        clr = 1; idle(1); clr = 0;

        // Overflow with downstream stalled for 40 beats
        for (int i = 0; i < 40; i++) drive(1, (i % 32) == 0, (i % 8) == 7, 0);
        chk("ovf_level", level, DEPTH);
        chk("ovf_tready", s_rdy, 0);
        chk("ovf_flag", ovf, 1);
        obs.delete();
        for (int i = 0; i < 20; i++) drive(0, 0, 0, 1);
        chk("ovf_drained", obs.size(), DEPTH);
        for (int i = 40; i < 64; i++) drive(1, 0, (i % 8) == 7, 1);
        idle(4);
        chk("ovf_cnt", frame_cnt, 6);
        clr = 1; idle(1); clr = 0;

        // Randomized frames, stalls, bad tlast, stray tuser and clears
        for (int f = 0; f < 30; f++) begin
            w = 2 + int'($urandom_range(0, 4));
            h = 1 + int'($urandom_range(0, 3));
            width_r = DIMW'(w);
            height_r = DIMW'(h);
            for (int c = 0; c < 40; c++) begin
                bit v, u, l;
                v = ($urandom_range(0, 3) != 0);
                if (!m_in_frame) begin
                    u = ($urandom_range(0, 2) == 0);
                    l = 0;
                end else begin
                    u = ($urandom_range(0, 40) == 0);
                    l = (((m_p % w) == w - 1) ^ ($urandom_range(0, 19) == 0));
                end
                clr = ($urandom_range(0, 30) == 0);
                drive(v, u, l, $urandom_range(0, 3) != 0);
                clr = 0;
                if (!m_in_frame && c > 20) break;
            end
        end
        width_r = 16'd8;
        height_r = 16'd4;
        idle(DEPTH + 4);

        // Reset mid-frame with 10 beats buffered
        clr = 1; idle(1); clr = 0;
        for (int i = 0; i < 10; i++) drive(1, i == 0, (i % 8) == 7, 0);
        chk("mid_level", level, 10);
        rst_n = 0;
        drive(0, 0, 0, 0);
        chk("mid_rst_tvalid", m_v, 0);
        chk("mid_rst_level", level, 0);
        rst_n = 1;
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 1);
        chk("mid_wait_sof", level, 0);

        // Same-cycle set and clear keeps the flag, a later clear drops it
        for (int i = 0; i < 5; i++) drive(1, i == 0, (i % 8) == 7, 1);
        clr = 1;
        drive(1, 0, 1, 1);
        clr = 0;
        chk("clr_prio", err_line, 1);
        for (int i = 6; i < 32; i++) drive(1, 0, (i % 8) == 7, 1);
        clr = 1; idle(1); clr = 0;
        chk("clr_flags", {err_line, err_sof, ovf}, 0);
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
